bandit_reel_ctrl: RTL



---
 rtl/bandit_pkg.sv | 37 +++
 rtl/bandit_reel_digit.sv | 41 ++++
 rtl/bandit_reel_ctrl.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/bandit_pkg.sv
// Shared definitions for the one-arm bandit game controller: FSM states,
// result codes, reel symbol count and per-reel step sizes.
package bandit_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SPIN3 = 3'd1,
      ST_SPIN2 = 3'd2,
      ST_SPIN1 = 3'd3,
      ST_EVAL  = 3'd4
   } state_e;

   localparam logic [1:0] RES_NONE    = 2'd0;
   localparam logic [1:0] RES_PAIR    = 2'd1;
   localparam logic [1:0] RES_JACKPOT = 2'd2;

   localparam int SYM_COUNT = 10;

   localparam logic [3:0] STEP0 = 4'd1;
   localparam logic [3:0] STEP1 = 4'd3;
   localparam logic [3:0] STEP2 = 4'd7;

   // Classify three reel symbols into a result code.
   function automatic logic [1:0] match_code(input logic [3:0] a,
                                             input logic [3:0] b,
                                             input logic [3:0] c);
      logic [1:0] code;
      code = RES_NONE;
      if ((a == b) && (b == c)) begin
         code = RES_JACKPOT;
      end else if ((a == b) || (b == c) || (a == c)) begin
         code = RES_PAIR;
      end
      return code;
   endfunction

endpackage

// File: rtl/bandit_reel_digit.sv
// One reel: a mod-10 symbol register that advances by STEP when enabled.
module bandit_reel_digit
   import bandit_pkg::*;
#(
   parameter logic [3:0] STEP = 4'd1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en_i,
   output logic [3:0] digit_o
);

   logic [3:0] digit_q;
   logic [3:0] digit_d;
   logic [4:0] sum;

   // Next symbol: add the step and fold back into 0..9 with one subtraction.
   always_comb begin
      sum     = {1'b0, digit_q} + {1'b0, STEP};
      digit_d = digit_q;
      if (en_i) begin
         if (sum >= 5'(SYM_COUNT)) begin
            digit_d = 4'(sum - 5'(SYM_COUNT));
         end else begin
            digit_d = sum[3:0];
         end
      end
   end

   // Symbol register, cleared to symbol 0 on reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         digit_q <= 4'd0;
      end else begin
         digit_q <= digit_d;
      end
   end

   assign digit_o = digit_q;

endmodule

// File: rtl/bandit_reel_ctrl.sv
// Game controller: accepts starts and coins, runs the three-reel spin with
// staggered stops, evaluates the outcome and keeps the saturating credit count.
module bandit_reel_ctrl
   import bandit_pkg::*;
#(
   parameter int TICK_DIV     = 2_500_000,
   parameter int SPIN_TICKS   = 20,
   parameter int GAP_TICKS    = 8,
   parameter int INIT_CREDITS = 10,
   parameter int PAIR_PAY     = 2,
   parameter int JACKPOT_PAY  = 10,
   parameter int CREDIT_MAX   = 99
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start_p,
   input  logic       coin_p,
   output logic [3:0] reel0,
   output logic [3:0] reel1,
   output logic [3:0] reel2,
   output logic [6:0] credits,
   output logic       busy,
   output logic       win_p,
   output logic [1:0] result
);

   localparam int              DIV_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
   localparam logic [7:0]      SPIN_LAST = 8'(SPIN_TICKS - 1);
   localparam logic [7:0]      GAP_LAST  = 8'(GAP_TICKS - 1);
   localparam logic [8:0]      CMAX      = 9'(CREDIT_MAX);
   localparam logic [8:0]      PAIR_AMT  = 9'(PAIR_PAY);
   localparam logic [8:0]      JACK_AMT  = 9'(JACKPOT_PAY);

   state_e           state_q, state_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [7:0]       cnt_q, cnt_d;
   logic [6:0]       cred_q, cred_d;
   logic [1:0]       res_q, res_d;

   logic       accept;
   logic       tick;
   logic       en0, en1, en2;
   logic [1:0] code;
   logic [8:0] pay;
   logic [8:0] cred_sum;

   // Clamp a widened credit sum to the ceiling.
   function automatic logic [6:0] sat_credit(input logic [8:0] v);
      logic [6:0] r;
      if (v > CMAX) begin
         r = CMAX[6:0];
      end else begin
         r = v[6:0];
      end
      return r;
   endfunction

   // Start acceptance, step tick, per-reel enables and the EVAL payout.
   always_comb begin
      accept = (state_q == ST_IDLE) && start_p && (cred_q != 7'd0);
      tick   = (state_q != ST_IDLE) && (div_q == DIV_LAST);
      en0    = tick && (state_q == ST_SPIN3);
      en1    = tick && ((state_q == ST_SPIN3) || (state_q == ST_SPIN2));
      en2    = tick && ((state_q == ST_SPIN3) || (state_q == ST_SPIN2) ||
                        (state_q == ST_SPIN1));
      code   = match_code(reel0, reel1, reel2);
      pay    = 9'd0;
      if (state_q == ST_EVAL) begin
         if (code == RES_JACKPOT) begin
            pay = JACK_AMT;
         end else if (code == RES_PAIR) begin
            pay = PAIR_AMT;
         end
      end
   end

   // Tick divider: idle at zero, wraps after TICK_DIV cycles while a game runs.
   always_comb begin
      div_d = div_q;
      if ((state_q == ST_IDLE) || tick) begin
         div_d = '0;
      end else begin
         div_d = div_q + DIV_W'(1);
      end
   end

   // Game sequencing: each spin stage ends on the tick that completes its count.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            cnt_d = 8'd0;
            if (accept) begin
               state_d = ST_SPIN3;
            end
         end
         ST_SPIN3: begin
            if (tick) begin
               if (cnt_q == SPIN_LAST) begin
                  state_d = ST_SPIN2;
                  cnt_d   = 8'd0;
               end else begin
                  cnt_d = cnt_q + 8'd1;
               end
            end
         end
         ST_SPIN2: begin
            if (tick) begin
               if (cnt_q == GAP_LAST) begin
                  state_d = ST_SPIN1;
                  cnt_d   = 8'd0;
               end else begin
                  cnt_d = cnt_q + 8'd1;
               end
            end
         end
         ST_SPIN1: begin
            if (tick) begin
               if (cnt_q == GAP_LAST) begin
                  state_d = ST_EVAL;
                  cnt_d   = 8'd0;
               end else begin
                  cnt_d = cnt_q + 8'd1;
               end
            end
         end
         ST_EVAL: begin
            state_d = ST_IDLE;
            cnt_d   = 8'd0;
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = 8'd0;
         end
      endcase
   end

   // Credits: coin and payout added, start fee taken, then clamped; result
   // clears on an accepted start and latches the outcome in EVAL.
   always_comb begin
      cred_sum = {2'b00, cred_q} + {8'd0, coin_p} + pay - {8'd0, accept};
      cred_d   = sat_credit(cred_sum);
      res_d    = res_q;
      if (accept) begin
         res_d = RES_NONE;
      end else if (state_q == ST_EVAL) begin
         res_d = code;
      end
   end

   // Control and bookkeeping registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         div_q   <= '0;
         cnt_q   <= 8'd0;
         cred_q  <= 7'(INIT_CREDITS);
         res_q   <= RES_NONE;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         cnt_q   <= cnt_d;
         cred_q  <= cred_d;
         res_q   <= res_d;
      end
   end

   bandit_reel_digit #(.STEP(STEP0)) u_reel0 (
      .clk     (clk),
      .rst_n   (rst_n),
      .en_i    (en0),
      .digit_o (reel0)
   );

   bandit_reel_digit #(.STEP(STEP1)) u_reel1 (
      .clk     (clk),
      .rst_n   (rst_n),
      .en_i    (en1),
      .digit_o (reel1)
   );

   bandit_reel_digit #(.STEP(STEP2)) u_reel2 (
      .clk     (clk),
      .rst_n   (rst_n),
      .en_i    (en2),
      .digit_o (reel2)
   );

   assign credits = cred_q;
   assign busy    = (state_q != ST_IDLE);
   assign win_p   = (state_q == ST_EVAL) && (pay != 9'd0);
   assign result  = res_q;

endmodule
